dffe_bank_arbiter: RTL and testbench
====================================

DFFE_BANK_ARBITER -- requirements
Module: dffe_bank_arbiter

Interface
REQ-001 The module SHALL provide parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The module SHALL provide parameter WIDTH, default 8, giving the width of the shared enable-gated register bank.
REQ-003 The module SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 The module SHALL have port clrn  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have port req  input  N_REQ  per-requester access request, level.
REQ-006 The module SHALL have port op  input  2*N_REQ  per-requester opcode: 00 load, 01 clear, 10 preset, 11 hold.
REQ-007 The module SHALL have port wdata  input  N_REQ*WIDTH  per-requester load data.
REQ-008 The module SHALL have port gnt  output  N_REQ  one-hot grant, at most one bit set.
REQ-009 The module SHALL have port done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 The module SHALL have port q  output  WIDTH  shared register bank contents.
REQ-011 The module SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT, RELEASE.
REQ-013 In IDLE, when any req bit is high, the FSM SHALL select a winner round-robin from pointer ptr, register it, and move to GRANT next cycle.
REQ-014 In GRANT, gnt SHALL be one-hot on the winner, and the bank SHALL apply the winner's op and wdata at the closing clk edge.
REQ-015 Op 00 SHALL load q with wdata; op 01 SHALL set q to all zeros; op 10 SHALL set q to all ones; op 11 SHALL leave q unchanged.
REQ-016 In RELEASE, done SHALL pulse for exactly one cycle on the winner's bit, gnt SHALL be zero, ptr SHALL become (winner+1) mod N_REQ, and the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be fixed: req sampled high at edge 0, gnt high after edge 1, q updated and done high after edge 2; throughput SHALL be one operation per 3 cycles.
REQ-018 If the winner's req is low during GRANT, the bank SHALL NOT be written, done SHALL NOT pulse, ptr SHALL NOT advance, and the FSM SHALL return directly to IDLE.
REQ-019 Requests arriving from non-winners while busy SHALL be held pending (level) and arbitrated at the next IDLE; none SHALL be lost or reordered beyond round-robin.
REQ-020 A winner whose req stays high after done SHALL be re-arbitrated as a new request, at lowest priority relative to ptr.
REQ-021 Op and wdata of non-granted requesters SHALL be ignored at all times.
REQ-022 The bank SHALL be written only in GRANT and only with the winner's inputs; q SHALL be stable in every other state.

Reset
REQ-023 While clrn is low, regardless of clk: state SHALL be IDLE; q, gnt, done and busy SHALL be 0; ptr SHALL be 0.
REQ-024 Reset asserted mid-operation (GRANT or RELEASE) SHALL abort the operation with no done pulse; the first arbitration after release SHALL start from requester 0.
REQ-025 Reset deassertion SHALL take effect at the first clk edge with clrn high; no operation SHALL begin on that same edge.

Structure
REQ-026 State encodings, opcode constants (OP_LOAD, OP_CLEAR, OP_PRESET, OP_HOLD) and default N_REQ/WIDTH SHALL reside in shared package dffe_bank_pkg.
REQ-027 Round-robin selection SHALL be one combinational sub-module rr_pick (inputs req, ptr; outputs one-hot winner, valid).
REQ-028 The bank SHALL be WIDTH flip-flops with a single write-enable from the FSM; there SHALL be no per-bit asynchronous preset or clear paths other than clrn.

Verification
REQ-029 Reset, req=0001, op0=00, wdata0=8'hA5 -> gnt=0001 after 1 cycle; q=8'hA5 and done=0001 after 2 cycles; ptr=1.
REQ-030 req=1111 held, all op=11 -> grants in order 0,1,2,3,0 at 3-cycle spacing; q unchanged; one done per grant.
REQ-031 q=8'h3C; req=0100 op2=10 then req=0010 op1=01 -> q=8'hFF, then q=8'h00.
REQ-032 req=1000 rises, then drops during GRANT -> no done, q unchanged, ptr unchanged, busy low after 2 cycles.
REQ-033 clrn pulsed low during GRANT of a load 8'h5A -> q=0, gnt=0, no done; next req=0011 grants requester 0 first.
REQ-034 Random req/op streams checked against a reference model -> gnt always one-hot or zero; done never without a preceding gnt; starvation-free within N_REQ grants.

Source files
------------

// File: rtl/dffe_bank_pkg.sv
// Shared definitions for the enable-gated register bank arbiter.
// Holds the FSM state encoding, the per-requester opcode constants and
// the default requester count and bank width used by the top and the
// round-robin picker.
package dffe_bank_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_HOLD   = 2'b11;

endpackage

// File: rtl/dffe_bank_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    - per-requester request levels
//   ptr    - index of the requester holding highest priority
//   winner - one-hot selected requester (zero when nothing requests)
//   valid  - high when a winner was found
module rr_pick
  import dffe_bank_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PW    = $clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  // Walk outward from ptr by distance d; the first requesting index wins.
  // Both loops are constant-bounded so every select is a constant index.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int d = 0; d < N_REQ; d++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!valid && req[j] && (((int'(ptr) + d) % N_REQ) == j)) begin
          winner[j] = 1'b1;
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dffe_bank_arbiter.sv
// Round-robin arbiter in front of a shared enable-gated register bank.
// One operation takes three cycles: IDLE picks a winner, GRANT applies the
// winner's opcode to the bank, RELEASE pulses done and advances the pointer.
// Ports:
//   clk   - rising-edge clock for all state
//   clrn  - asynchronous active-low reset
//   req   - per-requester request levels
//   op    - per-requester opcode (2 bits each): load, clear, preset, hold
//   wdata - per-requester load data (WIDTH bits each)
//   gnt   - one-hot grant, high during GRANT
//   done  - one-cycle completion pulse, high during RELEASE
//   q     - shared bank contents
//   busy  - high whenever the FSM is not IDLE
module dffe_bank_arbiter
  import dffe_bank_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
);

  localparam int PW = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             armed_q, armed_d;

  logic [N_REQ-1:0] pick_winner;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_wdata;
  logic             win_req;
  logic             bank_we;
  logic [WIDTH-1:0] bank_next;

  rr_pick #(
    .N_REQ(N_REQ),
    .PW   (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .winner(pick_winner),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_winner[i]) pick_idx = PW'(i);
    end
  end

  // Only the registered winner's lanes ever reach the bank, so other
  // requesters' opcodes and data are ignored by construction.
  always_comb begin
    win_op    = OP_HOLD;
    win_wdata = '0;
    win_req   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_q == PW'(i)) begin
        win_op    = op[2*i +: 2];
        win_wdata = wdata[i*WIDTH +: WIDTH];
        win_req   = req[i];
      end
    end
  end

  always_comb begin
    unique case (win_op)
      OP_LOAD:   bank_next = win_wdata;
      OP_CLEAR:  bank_next = '0;
      OP_PRESET: bank_next = '1;
      default:   bank_next = q_q;
    endcase
  end

  // armed_q blocks arbitration on the first edge after reset release.
  // The winner dropping its request in GRANT aborts without writing,
  // pulsing done or moving the pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    done_d  = '0;
    armed_d = 1'b1;
    bank_we = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && pick_valid) begin
          win_d   = pick_idx;
          gnt_d   = pick_winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (win_req) begin
          bank_we = 1'b1;
          done_d  = gnt_q;
          ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    q_d    = bank_we ? bank_next : q_q;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign q    = q_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_dffe_bank_arbiter.sv
// Self-checking bench for dffe_bank_arbiter with N_REQ=4, WIDTH=8.
// A transaction-level model predicts gnt/done/q/busy every cycle; directed
// sequences add literal expectations for the documented scenarios.
module tb_dffe_bank_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  logic            clk;
  logic            clrn;
  logic [NR-1:0]   req;
  logic [2*NR-1:0] op;
  logic [NR*W-1:0] wdata;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic [W-1:0]    q;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  dffe_bank_arbiter #(.N_REQ(NR), .WIDTH(W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .req  (req),
    .op   (op),
    .wdata(wdata),
    .gnt  (gnt),
    .done (done),
    .q    (q),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an operation is "none", "granted" or "completed"; the winner is
  // the first requesting index at or after the pointer, wrapping around.
  int            m_stage = 0;
  int            m_win   = 0;
  int            m_ptr   = 0;
  logic [W-1:0]  m_q     = '0;
  bit            m_armed = 1'b0;
  logic [NR-1:0] req_s   = '0;

  always @(posedge clk or negedge clrn) begin
    logic [1:0] mop;
    bit found;
    if (!clrn) begin
      m_stage = 0; m_win = 0; m_ptr = 0; m_q = '0; m_armed = 1'b0; req_s = '0;
    end else begin
      req_s = req;
      if (m_stage == 1) begin
        if (req[m_win]) begin
          mop = op[2*m_win +: 2];
          if (mop == 2'b00) m_q = wdata[m_win*W +: W];
          else if (mop == 2'b01) m_q = '0;
          else if (mop == 2'b10) m_q = '1;
          m_ptr   = (m_win + 1) % NR;
          m_stage = 2;
        end else begin
          m_stage = 0;
        end
      end else if (m_stage == 2) begin
        m_stage = 0;
      end else if (m_armed && req != '0) begin
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
          if (!found && req[(m_ptr + k) % NR]) begin
            m_win = (m_ptr + k) % NR;
            found = 1'b1;
          end
        end
        m_stage = 1;
      end
      m_armed = 1'b1;
    end
  end

  // Per-cycle comparison against the model plus structural invariants.
  logic [NR-1:0] prev_gnt = '0;
  int            wait_cnt [NR];
  initial for (int i = 0; i < NR; i++) wait_cnt[i] = 0;

  always @(negedge clk) begin
    logic [NR-1:0] eg, ed;
    eg = (m_stage == 1) ? NR'(1 << m_win) : '0;
    ed = (m_stage == 2) ? NR'(1 << m_win) : '0;
    cmp("model.gnt", 8'(gnt), 8'(eg));
    cmp("model.done", 8'(done), 8'(ed));
    cmp("model.q", q, m_q);
    cmp("model.busy", 8'(busy), 8'(m_stage != 0));
    cmp("gnt_onehot0", 8'($onehot0(gnt)), 8'd1);
    if (done != '0) cmp("done_after_gnt", 8'(done & ~prev_gnt), 8'd0);
    for (int i = 0; i < NR; i++) begin
      if (!req_s[i] || done[i]) wait_cnt[i] = 0;
      else if (done != '0) begin
        wait_cnt[i]++;
        cmp("starvation", 8'(wait_cnt[i] > NR), 8'd0);
      end
    end
    prev_gnt = gnt;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r, input logic [2*NR-1:0] o,
                               input logic [NR*W-1:0] w);
    req = r; op = o; wdata = w;
  endtask

  task automatic checkOutput(input string nm, input logic [NR-1:0] g, input logic [NR-1:0] d,
                             input logic [W-1:0] qv, input logic b);
    cmp({nm, ".gnt"}, 8'(gnt), 8'(g));
    cmp({nm, ".done"}, 8'(done), 8'(d));
    cmp({nm, ".q"}, q, qv);
    cmp({nm, ".busy"}, 8'(busy), 8'(b));
  endtask

  task automatic doReset();
    #2 clrn = 1'b0;
    tick(2);
    #2 clrn = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clrn = 1'b0;
    applyStimulus('0, '0, '0);
    tick(2);
    checkOutput("reset", 4'b0000, 4'b0000, 8'h00, 1'b0);
    #2 clrn = 1'b1;
    tick(1);

    // Single load from requester 0.
    applyStimulus(4'b0001, 8'h00, 32'h0000_00A5);
    tick(1); checkOutput("load_a5_gnt", 4'b0001, 4'b0000, 8'h00, 1'b1);
    tick(1); checkOutput("load_a5_done", 4'b0000, 4'b0001, 8'hA5, 1'b1);
    applyStimulus('0, '0, '0);
    tick(1); checkOutput("load_a5_idle", 4'b0000, 4'b0000, 8'hA5, 1'b0);

    // Pointer now 1; requester 1 wins, then aborts by dropping req.
    applyStimulus(4'b0011, 8'hFF, '0);
    tick(1); checkOutput("ptr_is_1", 4'b0010, 4'b0000, 8'hA5, 1'b1);
    applyStimulus('0, 8'hFF, '0);
    tick(1); checkOutput("abort_idle", 4'b0000, 4'b0000, 8'hA5, 1'b0);

    // All requesting with hold: grants 0,1,2,3,0 every 3 cycles.
    doReset();
    applyStimulus(4'b1111, 8'hFF, 32'hDEAD_BEEF);
    for (int g = 0; g < 5; g++) begin
      tick(1); checkOutput("rr_gnt", 4'(1 << (g % 4)), 4'b0000, 8'h00, 1'b1);
      tick(1); checkOutput("rr_done", 4'b0000, 4'(1 << (g % 4)), 8'h00, 1'b1);
      tick(1); checkOutput("rr_idle", 4'b0000, 4'b0000, 8'h00, 1'b0);
    end
    applyStimulus('0, '0, '0);

    // q=3C, then preset from requester 2, then clear from requester 1.
    applyStimulus(4'b0001, 8'h00, 32'h0000_003C);
    tick(2); checkOutput("load_3c", 4'b0000, 4'b0001, 8'h3C, 1'b1);
    applyStimulus('0, '0, '0);
    tick(1);
    applyStimulus(4'b0100, 8'h20, 32'h1122_3344);
    tick(1); checkOutput("preset_gnt", 4'b0100, 4'b0000, 8'h3C, 1'b1);
    tick(1); checkOutput("preset_done", 4'b0000, 4'b0100, 8'hFF, 1'b1);
    applyStimulus('0, '0, '0);
    tick(1);
    applyStimulus(4'b0010, 8'h04, 32'h5566_7788);
    tick(1); checkOutput("clear_gnt", 4'b0010, 4'b0000, 8'hFF, 1'b1);
    tick(1); checkOutput("clear_done", 4'b0000, 4'b0010, 8'h00, 1'b1);
    applyStimulus('0, '0, '0);
    tick(1);

    // Requester 3 drops req during GRANT: no write, pointer stays at 2.
    applyStimulus(4'b1000, 8'h00, 32'h9900_0000);
    tick(1); checkOutput("drop_gnt", 4'b1000, 4'b0000, 8'h00, 1'b1);
    applyStimulus('0, 8'h00, 32'h9900_0000);
    tick(1); checkOutput("drop_abort", 4'b0000, 4'b0000, 8'h00, 1'b0);
    applyStimulus(4'b1111, 8'hFF, '0);
    tick(1); checkOutput("drop_ptr", 4'b0100, 4'b0000, 8'h00, 1'b1);
    applyStimulus('0, 8'hFF, '0);
    tick(1); checkOutput("drop_ptr_idle", 4'b0000, 4'b0000, 8'h00, 1'b0);

    // Load C3 via requester 1, then reset in the middle of a 5A load.
    applyStimulus(4'b0010, 8'h00, 32'h0000_C300);
    tick(2); checkOutput("load_c3", 4'b0000, 4'b0010, 8'hC3, 1'b1);
    applyStimulus('0, '0, '0);
    tick(1);
    applyStimulus(4'b0001, 8'h00, 32'h0000_005A);
    tick(1); checkOutput("mid_rst_gnt", 4'b0001, 4'b0000, 8'hC3, 1'b1);
    #2 clrn = 1'b0;
    #1 checkOutput("mid_rst", 4'b0000, 4'b0000, 8'h00, 1'b0);
    tick(1);
    applyStimulus(4'b0011, 8'hFF, '0);
    #2 clrn = 1'b1;
    tick(1); checkOutput("arm_edge", 4'b0000, 4'b0000, 8'h00, 1'b0);
    tick(1); checkOutput("post_rst_gnt0", 4'b0001, 4'b0000, 8'h00, 1'b1);
    tick(1); checkOutput("post_rst_done0", 4'b0000, 4'b0001, 8'h00, 1'b1);
    tick(2); checkOutput("post_rst_gnt1", 4'b0010, 4'b0000, 8'h00, 1'b1);
    applyStimulus('0, '0, '0);
    tick(3);

    // Random streams, biased towards requests that stay high.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(4'($urandom) | 4'($urandom), 8'($urandom), $urandom);
      tick(1);
    end
    applyStimulus('0, '0, '0);
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
